// File: rtl/mm_ctrl_pkg.sv
// Shared types and helpers for the matrix-multiplier controllers.
// Holds the feed sequencer state encoding and the drain length rule.
package mm_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE,
    FLUSH
  } feed_state_t;

  // Zero-fill beats needed to push the last operand through skew and array.
  function automatic int drain_len(input int h, input int w);
    return h + w - 2;
  endfunction

endpackage

// File: rtl/systolic_feed_ctrl.sv
// Input-path sequencer for the systolic matrix multiplier.
// Clears, feeds k_len beats, zero-fills the drain, then flags the result.
module systolic_feed_ctrl
  import mm_ctrl_pkg::*;
#(
  parameter int ARRAY_HEIGHT = 4,
  parameter int ARRAY_WIDTH  = 4,
  parameter int K_MAX        = 256,
  parameter int CNT_W        = $clog2(K_MAX + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] k_len,
  input  logic             abort,
  input  logic             src_valid,
  output logic             src_ready,
  output logic             shift,
  output logic             zero_fill,
  output logic             sync_reset,
  output logic             acc_clear,
  output logic             busy,
  output logic             result_valid,
  output logic             done
);

  localparam int D = drain_len(ARRAY_HEIGHT, ARRAY_WIDTH);
  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(D - 1);
  localparam logic [CNT_W-1:0] K_CAP  = CNT_W'(K_MAX);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  feed_state_t      state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] klen_q, klen_nx;

  // State, shared beat/drain counter and latched pass length.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      klen_q <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      klen_q <= klen_nx;
    end
  end

  // Next-state logic; abort wins over a beat or drain step.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    klen_nx  = klen_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (k_len == '0) begin
            state_nx = DONE;
          end else begin
            state_nx = CLEAR;
            cnt_nx   = '0;
            klen_nx  = (k_len > K_CAP) ? K_CAP : k_len;
          end
        end
      end
      CLEAR: begin
        state_nx = abort ? FLUSH : FEED;
      end
      FEED: begin
        if (abort) begin
          state_nx = FLUSH;
          cnt_nx   = '0;
        end else if (src_valid) begin
          if (cnt == klen_q - ONE) begin
            state_nx = DRAIN;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + ONE;
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          state_nx = FLUSH;
          cnt_nx   = '0;
        end else if (cnt == D_LAST) begin
          state_nx = DONE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
      DONE:    state_nx = IDLE;
      FLUSH:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output decode; everything is held low while reset is asserted.
  always_comb begin
    src_ready    = 1'b0;
    shift        = 1'b0;
    zero_fill    = 1'b0;
    sync_reset   = 1'b0;
    acc_clear    = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;
    done         = 1'b0;
    if (reset_n) begin
      unique case (state)
        IDLE: ;
        CLEAR, FLUSH: begin
          sync_reset = 1'b1;
          acc_clear  = 1'b1;
          busy       = 1'b1;
        end
        FEED: begin
          src_ready = 1'b1;
          shift     = src_valid & ~abort;
          busy      = 1'b1;
        end
        DRAIN: begin
          shift     = ~abort;
          zero_fill = 1'b1;
          busy      = 1'b1;
        end
        DONE: begin
          result_valid = 1'b1;
          done         = 1'b1;
          busy         = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/systolic_feed_ctrl.md
# systolic_feed_ctrl

Sequencer for the matrix-multiplier input path. It runs one multiply pass at a time. For each pass it clears the row skew crossbar and the PE accumulators, streams `k_len` operand beats from the operand buffer through the crossbar, zero-fills long enough to drain the skew and the array, and then flags the result. It sits between the operand buffer and the `row_crossbar`/systolic array, and drives their `shift` and `sync_reset` inputs.

## Interface
- `ARRAY_HEIGHT`, 4: rows of the PE array; sets the skew depth.
- `ARRAY_WIDTH`, 4: columns of the PE array.
- `K_MAX`, 256: largest supported inner dimension.
- `CNT_W`, `$clog2(K_MAX+1)`: derived width of `k_len` and of the internal counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: reset is synchronous and active-low.
- `start` in 1: request a pass. Sampled only in IDLE.
- `k_len` in CNT_W: beats per pass. Sampled together with `start`.
- `abort` in 1: cancel the pass in progress.
- `src_valid` in 1: operand buffer has a beat.
- `src_ready` out 1: controller accepts the beat.
- `shift` out 1: advance the crossbar and array.
- `zero_fill` out 1: selects zero instead of buffer data at the crossbar input.
- `sync_reset` out 1: clears the crossbar registers.
- `acc_clear` out 1: clears the PE accumulators.
- `busy` out 1: pass in progress.
- `result_valid` out 1: array outputs hold the finished result.
- `done` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, DONE, FLUSH.
- IDLE:
  - `start=1` with `k_len≠0`: latch `min(k_len, K_MAX)`, go to CLEAR.
  - `start=1` with `k_len=0`: go to DONE with no CLEAR, FEED or DRAIN.
  - `start` outside IDLE is ignored.
- CLEAR (1 cycle): `sync_reset=1`, `acc_clear=1`, then go to FEED.
- FEED:
  - `src_ready=1`; `shift = src_valid` (combinational).
  - The counter increments on each accepted beat.
  - On the accepted beat where the counter equals `k_len-1`, go to DRAIN and reset the counter.
  - With `src_valid=0`: `shift=0` and the counter holds.
- DRAIN:
  - `shift=1` and `zero_fill=1` for exactly D = `ARRAY_HEIGHT+ARRAY_WIDTH-2` cycles, then go to DONE.
  - `src_ready=0`.
- DONE (1 cycle): `result_valid=1`, `done=1`, then go to IDLE.
- `abort=1` in CLEAR, FEED or DRAIN: go to FLUSH.
  - Abort takes priority over a beat or drain step in the same cycle; `shift=0` that cycle.
- FLUSH (1 cycle): `sync_reset=1`, `acc_clear=1`, no `done`, then go to IDLE.
- `abort` in IDLE or DONE is ignored.
- Output decode:
  - `shift` and `src_ready` are decoded from the current state plus `src_valid`.
  - All other outputs are decoded from the current state only.
  - `busy=1` in every state except IDLE.

## Timing
- Reset values: state IDLE, counter 0, latched `k_len` 0. Every output is 0 while `reset_n=0` and in the first cycle after release.
- Reset during a pass: IDLE at the next edge, no `done`, no `sync_reset` pulse. The crossbar is reset by its own `reset_n`.
- With `start` at cycle 0 and `src_valid` held high:
  - CLEAR at cycle 1.
  - `shift` at cycles 2..K+1.
  - DRAIN at cycles K+2..K+1+D.
  - DONE at cycle K+2+D.
  - IDLE at cycle K+3+D. The earliest next `start` is accepted in that cycle.
- Each cycle with `src_valid=0` in FEED adds exactly one cycle of latency.
- Zero-length pass: DONE at cycle 1, IDLE at cycle 2.
- Counter:
  - Counts from 0 to `max(k_len, D)-1`.
  - Never wraps within a pass.
  - Width CNT_W, and `D ≤ K_MAX` is required.

## Structure
- Shared package `mm_ctrl_pkg` holds:
  - the `feed_state_t` enum (IDLE, CLEAR, FEED, DRAIN, DONE, FLUSH);
  - the function `drain_len(h, w) = h+w-2`.
- Single module. One counter is shared between FEED and DRAIN. No sub-module.

## Test plan
All scenarios use H=4, W=4, D=6.
- `k_len=3`, `start` at cycle 0, `src_valid=1` → `sync_reset` and `acc_clear` at cycle 1; `shift` at cycles 2–4 with `zero_fill=0`; `shift` and `zero_fill` at cycles 5–10; `done` and `result_valid` at cycle 11; `busy` high at cycles 1–11.
- `k_len=4`, `src_valid` pattern 1,0,0,1,1,0,1 from cycle 2 → `shift` high exactly in the 4 valid cycles (2, 5, 6, 8); DRAIN at cycles 9–14; `done` at cycle 15.
- `k_len=0` → `done` at cycle 1 only; `shift`, `sync_reset` and `src_ready` never assert.
- `k_len=5`, `abort` in the 3rd DRAIN cycle → `shift=0` that cycle; FLUSH the next cycle with `sync_reset=1`; then IDLE; `done` never asserts.
- `reset_n=0` for 1 cycle mid-FEED → all outputs 0 from the next edge; a subsequent `start` with `k_len=2` completes with `done` 10 cycles later.
- `start` held high, `k_len=1` → back-to-back passes; each new CLEAR follows one IDLE cycle; `start` during `busy` never restarts a pass.
